// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, constants and block-count helper.
package sha256_pkg;
  typedef enum logic [2:0] {IDLE, DATA, ONE, ZERO, LEN_HI, LEN_LO} pad_state_e;
  localparam int SHA256_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;
  function automatic logic [32:0] sha256_num_blocks(input logic [31:0] len_words);
    return ({1'b0, len_words} + 33'd18) >> 4;
  endfunction
endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: message-in / word-out streams plus start/status of the padder.
interface sha256_msg_padder_if #(parameter int LEN_W = 16);
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             out_eob;
  logic             out_last;
  logic             busy;
  logic             done;
  modport slave (input start, msg_len, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_eob, out_last, busy, done);
  modport master (output start, msg_len, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_eob, out_last, busy, done);
endinterface

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: appends SHA-256 delimiter, zero fill and bit length to a word stream.
// Optional SHA256_PAD_BLKIDX_EN adds blk_idx and num_blocks outputs.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic reset_n,
  sha256_msg_padder_if.slave bus
`ifdef SHA256_PAD_BLKIDX_EN
  ,
  output logic [LEN_W-1:0] blk_idx,
  output logic [LEN_W:0]   num_blocks
`endif
);
  pad_state_e       state, state_nx;
  logic [3:0]       wcnt;
  logic [LEN_W-1:0] rem, n, blk;
  logic [LEN_W:0]   nblk, nblk_calc;
  logic [63:0]      bit_len;
  logic             xfer, done_q, accept;
  assign nblk_calc = (LEN_W+1)'(sha256_num_blocks(32'(bus.msg_len)));
  assign bit_len   = 64'(n) << 5;
  assign xfer      = bus.out_valid & bus.out_ready;
  // a start coinciding with the done pulse is deliberately dropped
  assign accept    = (state == IDLE) & bus.start & ~done_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt   <= '0;
      rem    <= '0;
      n      <= '0;
      blk    <= '0;
      nblk   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == LEN_LO) & xfer;
      if (accept) begin
        n    <= bus.msg_len;
        rem  <= bus.msg_len;
        wcnt <= '0;
        blk  <= '0;
        nblk <= nblk_calc;
      end else if (xfer) begin
        wcnt <= wcnt + 4'd1;
        if (state == DATA) rem <= rem - LEN_W'(1);
        if (wcnt == 4'd15) blk <= blk + LEN_W'(1);
      end
    end
  end
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    case (state)
      IDLE: if (accept) state_nx = (bus.msg_len != '0) ? DATA : ONE;
      DATA: begin
        bus.out_valid = bus.in_valid;
        bus.out_data  = bus.in_data;
        bus.in_ready  = bus.out_ready;
        if (xfer && rem == LEN_W'(1)) state_nx = ONE;
      end
      ONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = SHA256_PAD_WORD;
        if (bus.out_ready) state_nx = (wcnt == 4'd13) ? LEN_HI : ZERO;
      end
      ZERO: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && wcnt == 4'd13) state_nx = LEN_HI;
      end
      LEN_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = bit_len[63:32];
        if (bus.out_ready) state_nx = LEN_LO;
      end
      LEN_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = bit_len[31:0];
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.out_eob  = (wcnt == 4'd15) & bus.out_valid;
  assign bus.out_last = bus.out_valid & ({1'b0, blk} == nblk - 1'b1);
  assign bus.busy     = state != IDLE;
  assign bus.done     = done_q;
`ifdef SHA256_PAD_BLKIDX_EN
  assign blk_idx    = blk;
  assign num_blocks = nblk;
`endif
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: randomized stimulus scoreboarded against a queue-built padding model.
module tb_sha256_msg_padder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, fails = 0;
  int idx = 0, in_ptr = 0, cur_n = 0, done_cnt = 0;
  bit active = 1'b0, done_seen = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [31:0] msg[$];
  logic [31:0] exp_q[$];

  sha256_msg_padder_if #(.LEN_W(16)) bus();
`ifdef SHA256_PAD_BLKIDX_EN
  logic [15:0] blk_idx;
  logic [16:0] num_blocks;
`endif

  sha256_msg_padder #(.LEN_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef SHA256_PAD_BLKIDX_EN
    ,
    .blk_idx(blk_idx),
    .num_blocks(num_blocks)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 0);
    chk({tag, "_out_data"}, 64'(bus.out_data), 0);
    chk({tag, "_out_eob"}, 64'(bus.out_eob), 0);
    chk({tag, "_out_last"}, 64'(bus.out_last), 0);
    chk({tag, "_busy"}, 64'(bus.busy), 0);
    chk({tag, "_done"}, 64'(bus.done), 0);
  endtask

  // Reference padding: data, delimiter, zeros up to position 14 mod 16, then 64-bit bit length.
  task automatic build_model(input int n);
    logic [63:0] bl;
    msg.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) msg.push_back($urandom);
    for (int i = 0; i < n; i++) exp_q.push_back(msg[i]);
    exp_q.push_back(32'h80000000);
    while (exp_q.size() % 16 != 14) exp_q.push_back(32'h0);
    bl = 64'(n) * 64'd32;
    exp_q.push_back(bl[63:32]);
    exp_q.push_back(bl[31:0]);
  endtask

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (active) begin
      if (bus.out_valid) begin
        if (idx < exp_q.size()) begin
          chk("out_data", 64'(bus.out_data), 64'(exp_q[idx]));
          chk("out_eob", 64'(bus.out_eob), 64'(idx % 16 == 15));
          chk("out_last", 64'(bus.out_last), 64'(idx >= exp_q.size() - 16));
        end else chk("extra_word", 64'(idx), 64'(exp_q.size()));
        if (prev_stall) chk("stall_stable", 64'(bus.out_data), 64'(prev_data));
      end
      chk("in_ready", 64'(bus.in_ready), 64'((idx < cur_n) ? bus.out_ready : 1'b0));
      if (bus.done) begin
        chk("done_idx", 64'(idx), 64'(exp_q.size()));
        done_seen = 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) idx++;
    end else prev_stall = 1'b0;
  end

  task automatic run_msg(input int n, input int gap, input int abort);
    int cyc, d0;
    build_model(n);
    idx = 0;
    in_ptr = 0;
    cur_n = n;
    done_seen = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.msg_len = 16'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.msg_len = 16'($urandom);
    active = 1'b1;
    cyc = 0;
    while (!done_seen && cyc < 2000 && !(abort >= 0 && idx >= abort)) begin
      bus.in_valid = (in_ptr < n) && ($urandom_range(99) >= gap);
      if (bus.in_valid) bus.in_data = msg[in_ptr];
      else bus.in_data = $urandom;
      bus.out_ready = $urandom_range(99) >= gap;
      bus.start = $urandom_range(3) == 0;
      bus.msg_len = 16'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) in_ptr++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    active = 1'b0;
    if (abort >= 0) begin
      reset_n = 1'b0;
      #1;
      check_reset("abort");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt), 64'(d0));
    end else begin
      chk("timeout", 64'(done_seen), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", 64'(bus.busy), 0);
      chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.msg_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #1;
    check_reset("rst");
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    run_msg(20, 0, -1);
    chk("m20_size", 64'(exp_q.size()), 32);
    chk("m20_pad", 64'(exp_q[20]), 64'h80000000);
    chk("m20_len", 64'(exp_q[31]), 64'h280);
    run_msg(13, 0, -1);
    chk("m13_size", 64'(exp_q.size()), 16);
    chk("m13_pad", 64'(exp_q[13]), 64'h80000000);
    chk("m13_len", 64'(exp_q[15]), 64'h1A0);
    run_msg(14, 0, -1);
    chk("m14_size", 64'(exp_q.size()), 32);
    chk("m14_pad", 64'(exp_q[14]), 64'h80000000);
    chk("m14_w15", 64'(exp_q[15]), 0);
    chk("m14_len", 64'(exp_q[31]), 64'h1C0);
    run_msg(0, 0, -1);
    chk("m0_size", 64'(exp_q.size()), 16);
    chk("m0_pad", 64'(exp_q[0]), 64'h80000000);
    run_msg(37, 30, -1);
    chk("m37_size", 64'(exp_q.size()), 48);
    for (int k = 0; k < 4; k++) run_msg(int'($urandom_range(1, 40)), 30, -1);
    run_msg(15, 30, -1);
    run_msg(20, 0, 9);
    run_msg(3, 0, -1);
    chk("m3_len", 64'(exp_q[15]), 64'h60);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream stage of the SHA-256 datapath that turns a raw word-granular message into the 512-bit block stream consumed by the hashing core. Message words arrive on a valid/ready stream. The block re-emits them as 32-bit words and appends the `0x80000000` delimiter, zero fill and the 64-bit big-endian bit length. It marks block and message boundaries, so the downstream core never computes block counts or padding itself.

## Interface
Parameters:
- `LEN_W`, default 16: width of the message length in words; the bit length N*32 must fit in 64 bits.

Ports:
- `clk`, input, 1: clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a message; sampled only in IDLE.
- `msg_len`, input, LEN_W: message length N in 32-bit words; sampled with `start`.
- `in_valid`, input, 1: input word valid.
- `in_data`, input, 32: input message word.
- `in_ready`, output, 1: padder accepts the input word.
- `out_valid`, output, 1: output word valid.
- `out_data`, output, 32: output word.
- `out_ready`, input, 1: downstream accepts the output word.
- `out_eob`, output, 1: the current output word is word 15 of a block.
- `out_last`, output, 1: the current output word belongs to the final block.
- `busy`, output, 1: a message is in progress.
- `done`, output, 1: one-cycle pulse after the final word transfers.

## Operation
- States: IDLE, DATA, ONE, ZERO, LEN_HI, LEN_LO.
- Counters: `wcnt[3:0]` is the word position within the block; `rem[LEN_W-1:0]` is the count of message words still to come.
- A transfer occurs when `out_valid & out_ready`. Every transfer increments `wcnt`, which wraps 15->0.
- IDLE + `start`: latch N, clear `wcnt`, assert `busy`. Go to DATA if N>0, else to ONE.
- DATA: pass-through.
  - `out_valid = in_valid`, `out_data = in_data`, `in_ready = out_ready`.
  - On each transfer decrement `rem`. The transfer with `rem==1` goes to ONE.
- ONE: emit `0x80000000`.
  - Go to LEN_HI if the next position is 14.
  - Otherwise go to ZERO.
- ZERO: emit `0x00000000` until the transfer at position 13, then go to LEN_HI.
  - If ONE landed at position 14 or 15, ZERO runs to the end of that block and then through positions 0..13 of the next block.
- LEN_HI: emit `(N*32)[63:32]`, which is 0 for LEN_W≤27.
- LEN_LO: emit `(N*32)[31:0]`, always at position 15.
  - On transfer: pulse `done`, clear `busy`, go to IDLE.
- `in_ready` is 0 in every state except DATA.
- `out_valid` is 1 in ONE, ZERO, LEN_HI and LEN_LO.
- `out_eob = (wcnt==15) & out_valid`.
- Final block: `out_last` is 1 for every word of the last block. The total is `ceil((N+3)/16)` blocks, computed at `start`.
- Arithmetic:
  - N*32 is a zero-extended left shift by 5.
  - The block count uses LEN_W+1 bits to avoid overflow at N=2^LEN_W-1.

## Timing
- Reset values: state IDLE, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_eob`=0, `out_last`=0, `busy`=0, `done`=0.
- Latency:
  - `start` -> first `out_valid` possible on the next cycle.
  - The DATA path is combinational, zero-cycle, with no internal storage.
  - Generated words present `out_valid` on the cycle after the state is entered.
- Handshake:
  - `out_data` holds stable while `out_valid & !out_ready`.
  - Stalls of any length are legal.
  - `in_valid` may drop between words without affecting output word order or content.
- `start` while `busy`: ignored, no effect.
- `start` in the same cycle as the `done` pulse: ignored; the padder accepts it only from the next cycle.
- `reset_n` low mid-message: immediate return to the reset values. The partial message is abandoned and no `done` is issued.
- `msg_len` changing after `start`: no effect, because N is latched.

## Configuration
- `SHA256_PAD_BLKIDX_EN` defined:
  - Adds output `blk_idx[LEN_W-1:0]`, the index of the block currently being emitted. It resets to 0, clears at `start`, and increments on each `out_eob` transfer.
  - Adds output `num_blocks[LEN_W:0]`, latched at `start`.
- Undefined: neither port exists. All other behaviour is identical.

## Structure
- Shared package `sha256_pkg`:
  - Padder state enum.
  - `SHA256_BLOCK_WORDS=16`.
  - `SHA256_PAD_WORD=32'h80000000`.
  - Function `sha256_num_blocks(len_words)` returning `ceil((len+3)/16)`; the hashing core reuses it.
- Flat module with no natural sub-module; the counters and the FSM are too small to split.

## Test plan
- N=20, `out_ready`=1: 32 words out.
  - Words 0..19 are data and word 20 is `0x80000000`.
  - Words 21..30 are 0 and word 31 is `0x00000280`.
  - `out_eob` is set at words 15 and 31; `out_last` is set on words 16..31; `done` pulses once.
- N=13: one block. Word 13 is `0x80000000`, word 14 is 0, word 15 is `0x000001A0`.
- N=14 (ONE at position 14): two blocks.
  - Word 14 is `0x80000000`, words 15..30 are 0, word 31 is `0x000001C0`.
  - `out_last` covers only the second block.
- N=0: one block. Word 0 is `0x80000000`, words 1..15 are 0; `in_ready` is never asserted.
- Random `in_valid`/`out_ready` gaps at 30% with N=37 are scoreboarded against the reference padding. Checks: no word lost or duplicated, and `out_data` stable while stalled.
- `reset_n` pulsed low at word 9 of N=20: all outputs are at their reset values the same cycle. A following `start` with N=3 yields the correct single block.
